// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared command/state encodings and packed-slice helper for the SDRAM arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {CMD_IDLE = 2'd0, CMD_WRITE = 2'd1, CMD_READ = 2'd2} cmd_e;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/sdram_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick searching upward from ptr+1 with wrap
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  logic found;
  // walk the candidates starting after the last owner; the first requester seen wins
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    j = ptr;
    for (int k = 0; k < N; k++) begin
      j = (j == IW'(N - 1)) ? '0 : j + 1'b1;
      if (!found && req[j]) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one SDRAM controller command port with a completion watchdog
module sdram_arbiter import sdram_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                command,
  output logic [ADDR_W-1:0]         data_address,
  output logic [DATA_W-1:0]         data_write,
  input  logic [DATA_W-1:0]         data_read,
  input  logic                      data_read_valid,
  input  logic                      data_write_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  cmd_e                command_q, command_d;
  logic [IW-1:0]       ptr_q, ptr_d, owner_q, owner_d, win_idx;
  logic [NUM_REQ-1:0]  win_gnt, rsp_valid_q, rsp_valid_d;
  logic                wr_q, wr_d, rsp_err_q, rsp_err_d, done, expired;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  // grants only exist while idle and out of reset, so a reset pulse kills them at once
  assign req_ready    = (state_q == IDLE && !rst) ? win_gnt : '0;
  assign done         = wr_q ? data_write_done : data_read_valid;
  assign expired      = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rdata_q;
  assign command      = command_q;
  assign data_address = addr_q;
  assign data_write   = wdata_q;

  // accept a winner in IDLE, run the command in BUSY until a matching strobe or the watchdog, pulse in RESP
  always_comb begin
    state_d = state_q;
    command_d = command_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rsp_err_d = rsp_err_q;
    rsp_valid_d = '0;
    cnt_d = cnt_q;
    if (state_q == IDLE && |win_gnt) begin
      wr_d = req_write[win_idx];
      addr_d = req_addr[slice_lo(int'(win_idx), ADDR_W) +: ADDR_W];
      wdata_d = req_wdata[slice_lo(int'(win_idx), DATA_W) +: DATA_W];
      owner_d = win_idx;
      ptr_d = win_idx;
      command_d = req_write[win_idx] ? CMD_WRITE : CMD_READ;
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
      if (done || expired) begin
        state_d = RESP;
        command_d = CMD_IDLE;
        rsp_valid_d[owner_q] = 1'b1;
        rsp_err_d = !done;
        rdata_d = (!wr_q && data_read_valid) ? data_read : '0;
      end
    end else if (state_q == RESP) begin
      state_d = IDLE;
      cnt_d = '0;
      rsp_err_d = 1'b0;
    end
  end

  // state and datapath registers; reset drops the command and forgets any pending transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      command_q <= CMD_IDLE;
      ptr_q <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_valid_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      command_q <= command_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rsp_err_q <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
